// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and level-width helper for the SPI slave core.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] SPI_DUMMY_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT_HI,
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

    function automatic int spi_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Host-side TX holding-register and RX FIFO handshake bundle of the SPI slave core.
interface spi_slave_core_if
    import spi_pkg::*;
#(
    parameter int RX_DEPTH = 16
);
    logic [SPI_BYTE_W-1:0]          tx_data;
    logic                           tx_valid;
    logic                           tx_ready;
    logic [SPI_BYTE_W-1:0]          rx_data;
    logic                           rx_valid;
    logic                           rx_ready;
    logic [spi_lvl_w(RX_DEPTH)-1:0] rx_level;

    modport slave  (input  tx_data, tx_valid, rx_ready,
                    output tx_ready, rx_data, rx_valid, rx_level);
    modport master (output tx_data, tx_valid, rx_ready,
                    input  tx_ready, rx_data, rx_valid, rx_level);
endinterface

// File: rtl/spi_slave_rx_fifo.sv
// First-word fall-through RX FIFO; a push while full is accepted only if a pop frees a slot.
module spi_slave_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [SPI_BYTE_W-1:0]       i_data,
    input  logic                        i_pop,
    output logic [SPI_BYTE_W-1:0]       o_data,
    output logic                        o_empty,
    output logic                        o_full,
    output logic [spi_lvl_w(DEPTH)-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = spi_lvl_w(DEPTH);

    logic [SPI_BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [LW-1:0]         r_level;
    logic                  w_pop, w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversampled SCLK/CS_N/MOSI, MSB-first bytes into an RX FIFO,
// TX bytes from a one-byte holding register (DUMMY_BYTE when empty).
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                    RX_DEPTH    = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] DUMMY_BYTE  = SPI_DUMMY_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_sclk,
    input  logic            i_cs_n,
    input  logic            i_mosi,
    output logic            o_miso,
    output logic            o_miso_oe,
    output logic            o_rx_overrun,
    output logic            o_tx_underrun,
    output logic            o_frame_done,
    output logic            o_busy,
    spi_slave_core_if.slave bus
);
    localparam int S = SYNC_STAGES;

    // Index S is an edge-history flop behind the S synchronizer stages.
    logic [S:0]            r_sclk_sync, r_cs_sync, r_mosi_sync, r_sync_vld;
    spi_state_e            r_state;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_shift_rx, r_shift_tx, r_hold;
    logic                  r_hold_full, r_tx_pend, r_pend_hold;
    logic                  r_miso, r_underrun, r_frame_done, r_overrun;

    logic                  w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_hi, w_mosi;
    logic                  w_push, w_pop, w_full, w_empty, w_tx_wr;
    logic [SPI_BYTE_W-1:0] w_ld_byte, w_rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[S-1:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[S-1:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[S-1:0], i_mosi};
            r_sync_vld  <= {r_sync_vld[S-1:0], 1'b1};
        end
    end

    assign w_sclk_rise = r_sclk_sync[S-1] & ~r_sclk_sync[S];
    assign w_sclk_fall = ~r_sclk_sync[S-1] & r_sclk_sync[S];
    assign w_cs_fall   = ~r_cs_sync[S-1] & r_cs_sync[S];
    assign w_cs_rise   = r_cs_sync[S-1] & ~r_cs_sync[S];
    assign w_cs_hi     = r_cs_sync[S-1] & r_cs_sync[S];
    assign w_mosi      = r_mosi_sync[S-1];

    assign w_ld_byte = r_hold_full ? r_hold : DUMMY_BYTE;
    assign w_rx_byte = {r_shift_rx[SPI_BYTE_W-2:0], w_mosi};
    assign w_tx_wr   = bus.tx_valid && !r_hold_full;
    assign w_push    = (r_state == ST_ACTIVE) && !w_cs_rise && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_pop     = bus.rx_valid && bus.rx_ready;

    // A byte-boundary reload happens on the fall after the 8th rise, which a master also
    // produces at the end of a frame; that reload is committed (holding register consumed
    // or underrun flagged) only when the next byte's first rise shows the master continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_HI;
            r_bit_cnt    <= '0;
            r_shift_rx   <= '0;
            r_shift_tx   <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_tx_pend    <= 1'b0;
            r_pend_hold  <= 1'b0;
            r_miso       <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= w_push && w_full && !w_pop;
            case (r_state)
                // Coming out of reset mid-frame: wait for a genuine idle CS before joining.
                ST_WAIT_HI: if (r_sync_vld[S] && w_cs_hi) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= ST_ACTIVE;
                        r_bit_cnt  <= '0;
                        r_shift_rx <= '0;
                        r_shift_tx <= w_ld_byte;
                        r_miso     <= w_ld_byte[SPI_BYTE_W-1];
                        r_tx_pend  <= 1'b0;
                        if (r_hold_full) r_hold_full <= 1'b0;
                        else             r_underrun  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state      <= ST_IDLE;
                        r_bit_cnt    <= '0;
                        r_miso       <= 1'b0;
                        r_tx_pend    <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift_rx <= w_rx_byte;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_tx_pend) begin
                            r_tx_pend <= 1'b0;
                            if (r_pend_hold) r_hold_full <= 1'b0;
                            else             r_underrun  <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt != 3'd0) begin
                            r_shift_tx <= {r_shift_tx[SPI_BYTE_W-2:0], 1'b0};
                            r_miso     <= r_shift_tx[SPI_BYTE_W-2];
                        end else begin
                            r_shift_tx  <= w_ld_byte;
                            r_miso      <= w_ld_byte[SPI_BYTE_W-1];
                            r_tx_pend   <= 1'b1;
                            r_pend_hold <= r_hold_full;
                        end
                    end
                end
                default: r_state <= ST_WAIT_HI;
            endcase
            if (w_tx_wr) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    spi_slave_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_rx_byte),
        .i_pop   (w_pop),
        .o_data  (bus.rx_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (bus.rx_level)
    );

    // Busy/OE follow the joined frame, so a CS already low at reset release stays undriven.
    assign bus.rx_valid   = !w_empty;
    assign bus.tx_ready   = !r_hold_full;
    assign o_miso         = r_miso;
    assign o_miso_oe      = (r_state == ST_ACTIVE);
    assign o_busy         = (r_state == ST_ACTIVE);
    assign o_rx_overrun   = r_overrun;
    assign o_tx_underrun  = r_underrun;
    assign o_frame_done   = r_frame_done;

endmodule
